uart_loop_monitor: RTL and testbench
====================================

# uart_loop_monitor

Parametrised serial loopback and frame monitor placed between the core's `tx_bit` output and `rx_bit` input in simulation and FPGA bring-up builds. It returns the transmit line to the receiver with one registered cycle of latency and optional single-cycle bit-flip injection. In parallel it decodes every UART frame on `tx_bit` into a first-word-fall-through capture FIFO and keeps saturating frame, framing-error and parity-error counters, so benches and debug logic can check traffic without a separate receiver model.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per bit (100 MHz / 115200); minimum 4.
- `DATA_BITS`, 8, data bits per frame, LSB first; range 5..9.
- `FIFO_DEPTH`, 16, capture FIFO entries; power of two, minimum 2.
- `clock` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high.
- `tx_bit` in 1: serial line driven by the core; idles high.
- `rx_bit` out 1: looped-back line to the core.
- `inject` in 1: when high, `rx_bit` is inverted for that cycle.
- `rd_valid` out 1: FIFO not empty.
- `rd_ready` in 1: pop the head entry when `rd_valid` is also high.
- `rd_data` out DATA_BITS: head entry data.
- `rd_ferr` out 1: head entry had a stop bit of 0.
- `rd_perr` out 1: head entry failed the parity check.
- `frame_count` out 16: completed frames, including dropped ones; saturates at 0xFFFF.
- `ferr_count` out 16: framing errors; saturates.
- `perr_count` out 16: parity errors; saturates.
- `overflow` out 1: sticky; set when a frame is dropped because the FIFO is full.

## Operation
- Loopback: `rx_bit` is the registered value of `tx_bit` XOR `inject`. `inject` is registered on the same edge as `tx_bit`.
- Monitor FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: a falling edge on `tx_bit` goes to START. The falling edge is registered `tx_q` = 1 with current `tx_bit` = 0. The baud counter loads 0.
- START: when the counter reaches `CLKS_PER_BIT/2 - 1`:
  - If `tx_bit` = 0, go to DATA and reset the counter.
  - If `tx_bit` = 1, treat it as a glitch and return to IDLE. No counter changes.
- DATA: sample `tx_bit` each time the counter reaches `CLKS_PER_BIT - 1`, then wrap the counter. Shift the sample in LSB first. After `DATA_BITS` samples:
  - go to PARITY if `UART_MON_PARITY_EN` is defined;
  - otherwise go to STOP.
- PARITY: take one sample, compare it against the expected parity (see Configuration), then go to STOP.
- STOP: take one sample (the middle of the stop bit). In that same cycle:
  - push {data, ferr = !sample, perr};
  - increment `frame_count`;
  - increment `ferr_count` if ferr is set;
  - increment `perr_count` if perr is set;
  - return to IDLE.
- Because STOP exits at mid-stop-bit, back-to-back frames are detected.
- FIFO push is accepted if the FIFO is not full, or if a pop happens in the same cycle. Otherwise the entry is dropped and `overflow` is set.
- A pop on an empty FIFO is ignored.
- Pointers are `$clog2(FIFO_DEPTH)+1` bits wide and wrap naturally. Full and empty are decoded from the MSB difference.
- All counters hold at 0xFFFF and never wrap.
- Reset applies at any time, including mid-frame, and does the following:
  - FSM goes to IDLE;
  - the partial frame is discarded;
  - FIFO is emptied;
  - counters are cleared and `overflow` is cleared;
  - `tx_q` is set to 1, so a line held low at reset release is not seen as a start bit.

## Timing
- Values during and after reset:
  - `rx_bit` = 1;
  - `rd_valid` = 0, `rd_data` = 0, `rd_ferr` = 0, `rd_perr` = 0;
  - all counters = 0, `overflow` = 0.
- Loopback latency: `rx_bit` follows `tx_bit` by exactly 1 clock.
- Start detection: the falling edge is recognised in the cycle `tx_bit` is first low.
- Data bit k (k from 0) is sampled `CLKS_PER_BIT/2 + (k+1)*CLKS_PER_BIT` cycles after that cycle.
- Push latency: `rd_valid` rises and the counters update 1 clock after the stop-bit sample.
- Pop: `rd_data` shows the next entry in the cycle after a `rd_valid` and `rd_ready` handshake.

## Configuration
- `UART_MON_PARITY_EN` defined:
  - each frame carries one even-parity bit between the data bits and the stop bit;
  - perr is set when (XOR of data bits) ≠ the parity sample.
- `UART_MON_PARITY_EN` undefined:
  - no PARITY state;
  - `rd_perr` and `perr_count` are tied to 0.

## Test plan
- Loopback: `tx_bit` pattern 1,0,0,1 with `inject` high in the third cycle → `rx_bit` = 1,0,1,1, each value one cycle late.
- Single frame, `CLKS_PER_BIT` = 16, data 0xA5, stop bit 1, `rd_ready` held low → `rd_valid` = 1, `rd_data` = 0xA5, `rd_ferr` = 0, `frame_count` = 1.
- Stop bit driven 0 with data 0x3C → entry 0x3C with `rd_ferr` = 1, `ferr_count` = 1.
- Low pulse of 4 cycles on an idle line (`CLKS_PER_BIT` = 16) → no push, `frame_count` stays 0.
- `FIFO_DEPTH` = 4, send 5 frames 0x01..0x05 with no pops:
  - `overflow` = 1, `frame_count` = 5;
  - popping yields 0x01..0x04, then `rd_valid` = 0.
- With `UART_MON_PARITY_EN`: send 0x07 with parity bit 0 → `rd_perr` = 1, `perr_count` = 1. Then assert `reset` mid-frame → all counters = 0, `rd_valid` = 0, the next clean frame 0x55 is captured correctly.

Source files
------------

// File: rtl/uart_loop_monitor.sv
// Serial loopback (1-cycle registered, with bit-flip injection) plus UART frame monitor,
// FWFT capture FIFO and saturating counters. Define UART_MON_PARITY_EN for even-parity frames.
module uart_loop_monitor #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tx_bit,
  output logic                 rx_bit,
  input  logic                 inject,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_ferr,
  output logic                 rd_perr,
  output logic [15:0]          frame_count,
  output logic [15:0]          ferr_count,
  output logic [15:0]          perr_count,
  output logic                 overflow
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 ferr;
    logic                 perr;
  } entry_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 tx_q, tx_d;
  logic                 rx_q, rx_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic [15:0]          ferr_cnt_q, ferr_cnt_d;
  logic [15:0]          perr_cnt_q, perr_cnt_d;
  logic                 overflow_q, overflow_d;

  logic   push, push_ok, pop, empty, full, at_bit_end;
  entry_t push_entry, head;
  entry_t mem_q [FIFO_DEPTH];

  assign tx_d = tx_bit;
  assign rx_d = tx_bit ^ inject;

  // Monitor FSM: next state, bit counters and the entry pushed at mid-stop-bit.
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    push       = 1'b0;
    push_entry = '0;
    at_bit_end = (cnt_q == FULL_M1);

    case (state_q)
      S_IDLE: begin
        if (tx_q && !tx_bit) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          if (!tx_bit) begin
            state_d = S_DATA;
            cnt_d   = '0;
            bit_d   = '0;
            perr_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (at_bit_end) begin
          cnt_d   = '0;
          shift_d = {tx_bit, shift_q[DATA_BITS-1:1]};
          if (bit_q == LAST_BIT) begin
`ifdef UART_MON_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef UART_MON_PARITY_EN
      S_PARITY: begin
        if (at_bit_end) begin
          cnt_d   = '0;
          perr_d  = (^shift_q) != tx_bit;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (at_bit_end) begin
          push            = 1'b1;
          push_entry.data = shift_q;
          push_entry.ferr = !tx_bit;
          push_entry.perr = perr_q;
          state_d         = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO control: a push into a full FIFO still lands if the head pops this cycle.
  always_comb begin
    empty       = (wr_ptr_q == rd_ptr_q);
    full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop         = rd_ready && !empty;
    push_ok     = push && (!full || pop);
    wr_ptr_d    = wr_ptr_q + PW'(push_ok);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    overflow_d  = overflow_q | (push && !push_ok);
    frame_cnt_d = sat_inc(frame_cnt_q, push);
    ferr_cnt_d  = sat_inc(ferr_cnt_q, push && push_entry.ferr);
    perr_cnt_d  = sat_inc(perr_cnt_q, push && push_entry.perr);
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      perr_q      <= 1'b0;
      tx_q        <= 1'b1;
      rx_q        <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_cnt_q <= '0;
      ferr_cnt_q  <= '0;
      perr_cnt_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      perr_q      <= perr_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_cnt_q <= frame_cnt_d;
      ferr_cnt_q  <= ferr_cnt_d;
      perr_cnt_q  <= perr_cnt_d;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone define
  // which entries are valid, and outputs are gated to zero while empty.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
  end

  assign head        = mem_q[rd_ptr_q[AW-1:0]];
  assign rx_bit      = rx_q;
  assign rd_valid    = !empty;
  assign rd_data     = empty ? '0 : head.data;
  assign rd_ferr     = !empty && head.ferr;
  assign rd_perr     = !empty && head.perr;
  assign frame_count = frame_cnt_q;
  assign ferr_count  = ferr_cnt_q;
  assign perr_count  = perr_cnt_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_uart_loop_monitor.sv
// Self-checking bench for uart_loop_monitor: table-driven loopback and frame vectors
// plus hand-written overflow and mid-frame-reset sequences.
module tb_uart_loop_monitor;

  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int FD  = 4;
`ifdef UART_MON_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset, tx_bit, inject, rd_ready;
  logic          rx_bit, rd_valid, rd_ferr, rd_perr, overflow;
  logic [DB-1:0] rd_data;
  logic [15:0]   frame_count, ferr_count, perr_count;

  int checks = 0;
  int errors = 0;
  int exp_frames, exp_ferrs, exp_perrs;

  uart_loop_monitor #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .FIFO_DEPTH(FD)) dut (
    .clock(clock), .reset(reset), .tx_bit(tx_bit), .rx_bit(rx_bit), .inject(inject),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_ferr(rd_ferr),
    .rd_perr(rd_perr), .frame_count(frame_count), .ferr_count(ferr_count),
    .perr_count(perr_count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic tx;
    logic inj;
    logic exp_rx;
  } loop_vec_t;

  typedef struct {
    logic [DB-1:0] data;
    logic          stop;
    logic          par_bad;
    logic          exp_ferr;
  } frame_vec_t;

  loop_vec_t  lvec[4];
  frame_vec_t fvec[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    tx_bit = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic par_bad);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    if (PAR_EN) send_bit((^d) ^ par_bad);
    send_bit(stop);
    tx_bit = 1'b1;
    tick(4);
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic apply_reset();
    tx_bit = 1'b1;
    reset  = 1'b1;
    tick(2);
    reset  = 1'b0;
    tick(2);
  endtask

  initial begin
    logic prev_rx;

    lvec[0] = '{1'b1, 1'b0, 1'b1};
    lvec[1] = '{1'b0, 1'b0, 1'b0};
    lvec[2] = '{1'b0, 1'b1, 1'b1};
    lvec[3] = '{1'b1, 1'b0, 1'b1};

    fvec[0] = '{8'hA5, 1'b1, 1'b0, 1'b0};
    fvec[1] = '{8'h3C, 1'b0, 1'b0, 1'b1};
    fvec[2] = '{8'h07, 1'b1, 1'b1, 1'b0};
    fvec[3] = '{8'hFF, 1'b1, 1'b0, 1'b0};
    fvec[4] = '{8'h00, 1'b0, 1'b1, 1'b1};

    // Reset, with the line driven low while reset is held.
    reset = 1'b1; tx_bit = 1'b0; inject = 1'b0; rd_ready = 1'b0;
    tick(2);
    check("rx_in_reset", rx_bit, 1);
    tx_bit = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("rst_rx_bit", rx_bit, 1);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_ferr", rd_ferr, 0);
    check("rst_rd_perr", rd_perr, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_ferr_count", ferr_count, 0);
    check("rst_perr_count", perr_count, 0);
    check("rst_overflow", overflow, 0);

    // Loopback: rx must hold the old value until the next edge, then follow.
    prev_rx = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_bit = lvec[i].tx;
      inject = lvec[i].inj;
      #1;
      check($sformatf("loop_hold_%0d", i), rx_bit, prev_rx);
      tick();
      check($sformatf("loop_rx_%0d", i), rx_bit, lvec[i].exp_rx);
      prev_rx = lvec[i].exp_rx;
    end
    inject = 1'b0;
    tx_bit = 1'b1;
    tick(2 * CPB);

    // Short low pulse is a glitch, not a frame.
    tx_bit = 1'b0;
    tick(4);
    tx_bit = 1'b1;
    tick(2 * CPB);
    check("glitch_frame_count", frame_count, 0);
    check("glitch_rd_valid", rd_valid, 0);

    // Frame table: capture, head fields, cumulative counters, then pop.
    exp_frames = 0; exp_ferrs = 0; exp_perrs = 0;
    for (int i = 0; i < 5; i++) begin
      send_frame(fvec[i].data, fvec[i].stop, fvec[i].par_bad);
      exp_frames++;
      if (fvec[i].exp_ferr) exp_ferrs++;
      if (PAR_EN && fvec[i].par_bad) exp_perrs++;
      check($sformatf("frm%0d_valid", i), rd_valid, 1);
      check($sformatf("frm%0d_data", i), rd_data, fvec[i].data);
      check($sformatf("frm%0d_ferr", i), rd_ferr, fvec[i].exp_ferr);
      check($sformatf("frm%0d_perr", i), rd_perr, PAR_EN && fvec[i].par_bad);
      check($sformatf("frm%0d_frame_count", i), frame_count, exp_frames);
      check($sformatf("frm%0d_ferr_count", i), ferr_count, exp_ferrs);
      check($sformatf("frm%0d_perr_count", i), perr_count, exp_perrs);
      pop_one();
      check($sformatf("frm%0d_empty_after_pop", i), rd_valid, 0);
    end
    check("table_overflow", overflow, 0);

    // Overflow: five frames into a four-entry FIFO with no pops.
    apply_reset();
    for (int i = 1; i <= 5; i++) send_frame(DB'(i), 1'b1, 1'b0);
    check("ovf_overflow", overflow, 1);
    check("ovf_frame_count", frame_count, 5);
    check("ovf_ferr_count", ferr_count, 0);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovf_valid_%0d", i), rd_valid, 1);
      check($sformatf("ovf_data_%0d", i), rd_data, i);
      pop_one();
    end
    check("ovf_drained", rd_valid, 0);

    // Pop on empty must be ignored; the next frame still lands intact.
    rd_ready = 1'b1;
    tick(3);
    rd_ready = 1'b0;
    send_frame(8'h66, 1'b1, 1'b0);
    check("after_empty_pop_valid", rd_valid, 1);
    check("after_empty_pop_data", rd_data, 8'h66);
    check("overflow_sticky", overflow, 1);
    check("after_empty_pop_count", frame_count, 6);

    // Reset mid-frame with an entry still queued.
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    tx_bit = 1'b1;
    reset  = 1'b1;
    tick(2);
    reset = 1'b0;
    tick();
    check("midrst_rd_valid", rd_valid, 0);
    check("midrst_rd_data", rd_data, 0);
    check("midrst_frame_count", frame_count, 0);
    check("midrst_ferr_count", ferr_count, 0);
    check("midrst_perr_count", perr_count, 0);
    check("midrst_overflow", overflow, 0);
    tick(2 * CPB);
    send_frame(8'h55, 1'b1, 1'b0);
    check("clean_valid", rd_valid, 1);
    check("clean_data", rd_data, 8'h55);
    check("clean_ferr", rd_ferr, 0);
    check("clean_perr", rd_perr, 0);
    check("clean_frame_count", frame_count, 1);
    pop_one();
    check("clean_drained", rd_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
